fma_dot_sequencer: RTL and testbench

- Initiator side of the fast fused multiply-add pipeline. Accepts one N-term signed dot-product job over a valid/ready handshake.
- Issues one FMA operation per term into an external fast_fp_fused_multiply_add instance, chaining each returned result back in as the next addend (c).
- Correlates returns using the FMA's external pipeline tag. Presents the final fixed_t result over a valid/ready output.
- Used by the RANSAC model-fit/residual stages for 3-term dot products.

---
 rtl/fma_dot_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fma_dot_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_dot_sequencer.sv
// Dot-product sequencer: issues one fused multiply-add per term into an external
// FMA pipeline and chains each tagged result back in as the next addend.
module fma_dot_sequencer #(
  parameter int unsigned N_TERMS = 3,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned FIXED_W = 32,
  localparam int unsigned IDX_W = (N_TERMS > 2) ? $clog2(N_TERMS) : 1,
  localparam int unsigned TAG_W = IDX_W + 2,
  localparam int unsigned OP_W = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_TERMS*FIXED_W-1:0] in_x,
  input  logic [N_TERMS*FIXED_W-1:0] in_y,
  input  logic [N_TERMS-1:0]         in_negate,
  input  logic [FIXED_W-1:0]         in_bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIXED_W-1:0]         out_result,
  output logic                       out_error,
  output logic [OP_W-1:0]            fma_opcode,
  output logic [FIXED_W-1:0]         fma_a,
  output logic [FIXED_W-1:0]         fma_b,
  output logic [FIXED_W-1:0]         fma_c,
  output logic [TAG_W-1:0]           fma_tag_i,
  input  logic [FIXED_W-1:0]         fma_r,
  input  logic [TAG_W-1:0]           fma_tag_o
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam int unsigned HOLD_W = $clog2(TIMEOUT + 1);
  localparam logic [OP_W-1:0]  OP_POS_A_POS_C = OP_W'(0);
  localparam logic [OP_W-1:0]  OP_NEG_A_POS_C = OP_W'(1);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     k, k_nxt;
  logic [FIXED_W-1:0]   acc, acc_nxt;
  logic                 job, job_nxt;
  logic                 err, err_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [HOLD_W-1:0]    hold, hold_nxt;
  logic [FIXED_W-1:0]   x_q [N_TERMS];
  logic [FIXED_W-1:0]   x_nxt [N_TERMS];
  logic [FIXED_W-1:0]   y_q [N_TERMS];
  logic [FIXED_W-1:0]   y_nxt [N_TERMS];
  logic [N_TERMS-1:0]   neg_q, neg_nxt;

  logic                 issue_nxt;
  logic                 in_ready_nxt, out_valid_nxt, out_error_nxt;
  logic [FIXED_W-1:0]   out_result_nxt, a_nxt, b_nxt, c_nxt;
  logic [OP_W-1:0]      opcode_nxt;
  logic [TAG_W-1:0]     tag_nxt;

  logic                 ret_valid, ret_job;
  logic [IDX_W-1:0]     ret_idx;

  assign ret_valid = fma_tag_o[TAG_W-1];
  assign ret_job   = fma_tag_o[TAG_W-2];
  assign ret_idx   = fma_tag_o[IDX_W-1:0];

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    acc_nxt   = acc;
    job_nxt   = job;
    err_nxt   = err;
    cnt_nxt   = cnt;
    hold_nxt  = (hold != '0) ? hold - HOLD_W'(1) : hold;
    x_nxt     = x_q;
    y_nxt     = y_q;
    neg_nxt   = neg_q;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < int'(N_TERMS); i++) begin
            x_nxt[i] = in_x[i*FIXED_W +: FIXED_W];
            y_nxt[i] = in_y[i*FIXED_W +: FIXED_W];
          end
          neg_nxt   = in_negate;
          acc_nxt   = in_bias;
          k_nxt     = '0;
          job_nxt   = ~job;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Held here until the post-reset discard window has lapsed.
        if (hold == '0) begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (ret_valid && (ret_job == job)) begin
          if (ret_idx == k) begin
            acc_nxt = fma_r;
            if (k == LAST_K) begin
              state_nxt = DONE;
            end else begin
              k_nxt     = k + IDX_W'(1);
              state_nxt = ISSUE;
            end
          end else begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
    endcase

    issue_nxt      = (state_nxt == ISSUE) && (hold_nxt == '0);
    in_ready_nxt   = (state_nxt == IDLE);
    out_valid_nxt  = (state_nxt == DONE);
    out_result_nxt = (state_nxt == DONE) ? acc_nxt : '0;
    out_error_nxt  = (state_nxt == DONE) ? err_nxt : 1'b0;
    a_nxt          = issue_nxt ? x_nxt[k_nxt] : '0;
    b_nxt          = issue_nxt ? y_nxt[k_nxt] : '0;
    c_nxt          = issue_nxt ? acc_nxt : '0;
    opcode_nxt     = (issue_nxt && neg_nxt[k_nxt]) ? OP_NEG_A_POS_C : OP_POS_A_POS_C;
    tag_nxt        = issue_nxt ? {1'b1, job_nxt, k_nxt} : '0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      k          <= '0;
      acc        <= '0;
      job        <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      hold       <= HOLD_W'(TIMEOUT);
      x_q        <= '{default: '0};
      y_q        <= '{default: '0};
      neg_q      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_error  <= 1'b0;
      fma_opcode <= OP_POS_A_POS_C;
      fma_a      <= '0;
      fma_b      <= '0;
      fma_c      <= '0;
      fma_tag_i  <= '0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      acc        <= acc_nxt;
      job        <= job_nxt;
      err        <= err_nxt;
      cnt        <= cnt_nxt;
      hold       <= hold_nxt;
      x_q        <= x_nxt;
      y_q        <= y_nxt;
      neg_q      <= neg_nxt;
      in_ready   <= in_ready_nxt;
      out_valid  <= out_valid_nxt;
      out_result <= out_result_nxt;
      out_error  <= out_error_nxt;
      fma_opcode <= opcode_nxt;
      fma_a      <= a_nxt;
      fma_b      <= b_nxt;
      fma_c      <= c_nxt;
      fma_tag_i  <= tag_nxt;
    end
  end

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Bench for fma_dot_sequencer: behavioural FMA stub with programmable latency,
// a per-cycle output checker against a dot-product model, and directed jobs.
module tb_fma_dot_sequencer;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 16;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 2;
  localparam int unsigned TW = IW + 2;
  localparam logic [1:0] OP_POS = 2'd0;
  localparam logic [1:0] OP_NEG = 2'd1;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_x, in_y;
  logic [N-1:0]   in_negate;
  logic [W-1:0]   in_bias;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic           out_error;
  logic [1:0]     fma_opcode;
  logic [W-1:0]   fma_a, fma_b, fma_c;
  logic [TW-1:0]  fma_tag_i;
  logic [W-1:0]   fma_r = 32'hDEAD_BEEF;
  logic [TW-1:0]  fma_tag_o = '0;

  always #5 clock = ~clock;

  fma_dot_sequencer #(.N_TERMS(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_negate(in_negate), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_error(out_error),
    .fma_opcode(fma_opcode), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_tag_i(fma_tag_i), .fma_r(fma_r), .fma_tag_o(fma_tag_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Q16.16 fused multiply-add with wrap-around accumulate.
  function automatic logic [31:0] fma_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic neg);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 16;
    if (neg) p = -p;
    return c + p[31:0];
  endfunction

  // Model of the job in flight.
  logic [31:0] mx [N];
  logic [31:0] my [N];
  logic [N-1:0] mneg;
  logic [31:0] mpart [N+1];
  logic        mjob = 1'b0;
  int          issue_idx = 0;
  logic        busy = 1'b0;
  int          exp_done = -1;
  logic [31:0] exp_result = '0;
  logic        exp_error = 1'b0;
  bit          chk_en = 1'b0;
  int          first_issue_cyc = -1;
  int          acc_cyc = 0;

  // FMA stub
  typedef struct {
    int          due;
    logic [31:0] r;
    logic [TW-1:0] tag;
  } ret_t;
  ret_t pipe [$];
  int   lat = 2;
  bit   drop = 1'b0;
  bit   corrupt = 1'b0;
  int   inj_cyc = -1;
  logic [TW-1:0] inj_tag = '0;

  always @(negedge clock) begin
    ret_t e;
    int   hi;
    if (fma_tag_i[TW-1] && !drop) begin
      e.due = cyc + lat;
      e.r   = fma_ref(fma_a, fma_b, fma_c, fma_opcode == OP_NEG);
      e.tag = fma_tag_i;
      if (corrupt) e.tag[0] = ~e.tag[0];
      pipe.push_back(e);
    end
    fma_tag_o = '0;
    fma_r     = 32'hDEAD_BEEF;
    hi = -1;
    for (int i = 0; i < pipe.size(); i++)
      if (hi < 0 && pipe[i].due == cyc) hi = i;
    if (hi >= 0) begin
      fma_tag_o = pipe[hi].tag;
      fma_r     = pipe[hi].r;
      pipe.delete(hi);
    end else if (cyc == inj_cyc) begin
      fma_tag_o = inj_tag;
      fma_r     = 32'h7777_0000;
    end
  end

  // Per-cycle output checker
  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(!busy));
      if (busy && exp_done >= 0) chk("out_valid", 64'(out_valid), 64'(cyc >= exp_done));
      else if (!busy) chk("out_valid_idle", 64'(out_valid), 64'(0));
      if (out_valid) begin
        chk("out_result", 64'(out_result), 64'(exp_result));
        chk("out_error", 64'(out_error), 64'(exp_error));
      end else begin
        chk("out_result_zero", 64'(out_result), 64'(0));
        chk("out_error_zero", 64'(out_error), 64'(0));
      end
      if (fma_tag_i[TW-1]) begin
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        chk("tag_idx", 64'(fma_tag_i[IW-1:0]), 64'(issue_idx));
        chk("tag_job", 64'(fma_tag_i[TW-2]), 64'(mjob));
        if (issue_idx < int'(N)) begin
          chk("fma_a", 64'(fma_a), 64'(mx[issue_idx]));
          chk("fma_b", 64'(fma_b), 64'(my[issue_idx]));
          chk("fma_c", 64'(fma_c), 64'(mpart[issue_idx]));
          chk("fma_opcode", 64'(fma_opcode), 64'(mneg[issue_idx] ? OP_NEG : OP_POS));
        end
        issue_idx++;
      end else begin
        chk("fma_idle_ab", 64'({fma_a, fma_b}), 64'(0));
        chk("fma_idle_c_op", 64'({fma_c, fma_opcode}), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a job in the current cycle; done_off < 0 skips the cycle-exact check.
  task automatic start_job(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                           input logic [31:0] y0, input logic [31:0] y1, input logic [31:0] y2,
                           input logic [N-1:0] neg, input logic [31:0] bias,
                           input bit aborts, input int done_off);
    mx[0] = x0; mx[1] = x1; mx[2] = x2;
    my[0] = y0; my[1] = y1; my[2] = y2;
    mneg = neg;
    mpart[0] = bias;
    for (int t = 0; t < int'(N); t++) mpart[t+1] = fma_ref(mx[t], my[t], mpart[t], mneg[t]);
    exp_result = aborts ? bias : mpart[N];
    exp_error  = aborts;
    mjob = ~mjob;
    issue_idx = 0;
    first_issue_cyc = -1;
    chk("accept_ready", 64'(in_ready), 64'(1));
    acc_cyc  = cyc;
    exp_done = (done_off < 0) ? -1 : cyc + done_off;
    in_x = {x2, x1, x0};
    in_y = {y2, y1, y0};
    in_negate = neg;
    in_bias = bias;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    busy = 1'b1;
    in_x = '1;
    in_y = '1;
    in_negate = '1;
    in_bias = 32'h5555_5555;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 64'(out_valid), 64'(1));
    if (exp_done >= 0) chk({name, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_done - acc_cyc));
  endtask

  task automatic finish_job(input int hold);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int release_cyc;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_negate = '0; in_bias = '0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_tag_i", 64'(fma_tag_i), 64'(0));
    chk("rst_result", 64'(out_result), 64'(0));
    reset_n = 1'b1;
    tick();
    chk("ready_after_release", 64'(in_ready), 64'(1));
    chk_en = 1'b1;
    repeat (TO + 2) tick();

    // Plain dot product: 1*4 + 2*5 + 3*6 = 32.0
    lat = 2;
    start_job(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
              32'h0004_0000, 32'h0005_0000, 32'h0006_0000,
              3'b000, 32'h0, 1'b0, 1 + N * (2 + 1));
    chk("model_pin_32", 64'(mpart[N]), 64'(32'h0020_0000));
    wait_done("t1");
    chk("t1_result", 64'(out_result), 64'(32'h0020_0000));
    chk("t1_error", 64'(out_error), 64'(0));
    finish_job(0);

    // Negated middle term with 0.5 bias: 4 - 10 + 18 + 0.5 = 12.5
    start_job(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
              32'h0004_0000, 32'h0005_0000, 32'h0006_0000,
              3'b010, 32'h0000_8000, 1'b0, 1 + N * (2 + 1));
    chk("model_pin_12p5", 64'(mpart[N]), 64'(32'h000C_8000));
    wait_done("t2");
    chk("t2_result", 64'(out_result), 64'(32'h000C_8000));
    finish_job(0);

    // Latency 1, negative values, consumer stalls 5 cycles: -3 + 2 - 1 + 1 = -1.0
    lat = 1;
    start_job(32'hFFFE_8000, 32'h0000_4000, 32'h0002_0000,
              32'h0002_0000, 32'h0008_0000, 32'hFFFF_8000,
              3'b000, 32'h0001_0000, 1'b0, 1 + N * (1 + 1));
    wait_done("t3");
    chk("t3_result", 64'(out_result), 64'(32'hFFFF_0000));
    finish_job(5);

    // Stub never returns: abort after TIMEOUT cycles with bias result
    drop = 1'b1;
    start_job(32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              3'b000, 32'h0003_0000, 1'b1, 1 + TO);
    wait_done("t4");
    chk("t4_result", 64'(out_result), 64'(32'h0003_0000));
    chk("t4_error", 64'(out_error), 64'(1));
    finish_job(0);
    drop = 1'b0;

    // Stale-job return injected during the first wait is ignored
    lat = 3;
    start_job(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
              32'h0004_0000, 32'h0005_0000, 32'h0006_0000,
              3'b000, 32'h0, 1'b0, 1 + N * (3 + 1));
    inj_tag = {1'b1, ~mjob, 2'b00};
    inj_cyc = acc_cyc + 2;
    wait_done("t5");
    chk("t5_result", 64'(out_result), 64'(32'h0020_0000));
    chk("t5_error", 64'(out_error), 64'(0));
    finish_job(0);
    inj_cyc = -1;

    // Return with the right job but wrong index ends the job with an error
    lat = 2;
    corrupt = 1'b1;
    start_job(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
              32'h0004_0000, 32'h0005_0000, 32'h0006_0000,
              3'b000, 32'h0000_4000, 1'b1, 2 + 2);
    wait_done("t6");
    chk("t6_error", 64'(out_error), 64'(1));
    finish_job(0);
    corrupt = 1'b0;

    // Reset while term 1 is in flight; its late return must not disturb the next job
    lat = 5;
    start_job(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
              32'h0004_0000, 32'h0005_0000, 32'h0006_0000,
              3'b000, 32'h0, 1'b0, 1 + N * (5 + 1));
    n = 0;
    while (issue_idx < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t7_term1_issued", 64'(issue_idx), 64'(2));
    chk_en = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("t7_rst_in_ready", 64'(in_ready), 64'(0));
    chk("t7_rst_tag_i", 64'(fma_tag_i), 64'(0));
    reset_n = 1'b1;
    busy = 1'b0;
    mjob = 1'b0;
    exp_done = -1;
    tick();
    release_cyc = cyc;
    chk_en = 1'b1;
    start_job(32'h0002_0000, 32'h0, 32'h0,
              32'h0003_0000, 32'h0, 32'h0,
              3'b000, 32'h0, 1'b0, -1);
    wait_done("t7");
    chk("t7_result", 64'(out_result), 64'(32'h0006_0000));
    chk("t7_error", 64'(out_error), 64'(0));
    chk("t7_holdoff", 64'(first_issue_cyc - release_cyc >= int'(TO) - 1), 64'(1));
    finish_job(0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
